// File: rtl/calc_top.sv
// 4-bit calculator: registered operands, signed 9-bit ALU result, and a
// 3-digit multiplexed common-anode seven-segment decimal display.
module calc_top #(
  parameter int REFRESH_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [6:0] out,
  output logic [2:0] invAn
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [3:0]        a_r;
  logic [3:0]        b_r;
  logic [2:0]        op_r;
  logic signed [8:0] res_n;
  logic              err_n;
  logic signed [8:0] res_r;
  logic              err_r;
  logic [CW-1:0]     cnt;
  logic [1:0]        idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r  <= 4'd0;
      b_r  <= 4'd0;
      op_r <= 3'd0;
    end else begin
      a_r  <= a;
      b_r  <= b;
      op_r <= op;
    end
  end

  always_comb begin
    res_n = 9'sd0;
    err_n = 1'b0;
    case (op_r)
      OP_ADD: res_n = $signed({5'd0, a_r} + {5'd0, b_r});
      OP_SUB: res_n = $signed({5'd0, a_r} - {5'd0, b_r});
      OP_MUL: res_n = $signed({1'b0, {4'd0, a_r} * {4'd0, b_r}});
      OP_DIV: begin
        if (b_r == 4'd0) err_n = 1'b1;
        else             res_n = $signed({5'd0, a_r / b_r});
      end
      OP_MOD: begin
        if (b_r == 4'd0) err_n = 1'b1;
        else             res_n = $signed({5'd0, a_r % b_r});
      end
      OP_AND: res_n = $signed({5'd0, a_r & b_r});
      OP_OR:  res_n = $signed({5'd0, a_r | b_r});
      OP_XOR: res_n = $signed({5'd0, a_r ^ b_r});
      default: res_n = 9'sd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_r <= 9'sd0;
      err_r <= 1'b0;
    end else begin
      res_r <= res_n;
      err_r <= err_n;
    end
  end

  // Decimal split of the magnitude (at most 225, so hundreds is 0..2).
  logic       neg;
  logic [7:0] mag;
  logic [7:0] rem;
  logic [3:0] hund;
  logic [3:0] tens;
  logic [3:0] units;
  logic [6:0] d2;
  logic [6:0] d1;
  logic [6:0] d0;

  always_comb begin
    neg = res_r[8];
    mag = neg ? 8'(-res_r) : res_r[7:0];
    if (mag >= 8'd200) begin
      hund = 4'd2;
      rem  = mag - 8'd200;
    end else if (mag >= 8'd100) begin
      hund = 4'd1;
      rem  = mag - 8'd100;
    end else begin
      hund = 4'd0;
      rem  = mag;
    end
    tens  = 4'(rem / 8'd10);
    units = 4'(rem % 8'd10);

    if (err_r) begin
      d2 = SEG_E;
      d1 = SEG_R;
      d0 = SEG_R;
    end else if (neg) begin
      d2 = SEG_MINUS;
      d1 = (mag < 8'd10) ? SEG_BLANK : seg7(tens);
      d0 = seg7(units);
    end else begin
      d2 = (hund == 4'd0) ? SEG_BLANK : seg7(hund);
      d1 = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg7(tens);
      d0 = seg7(units);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Segment and anode are registered together so they always switch on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out   <= SEG_BLANK;
      invAn <= 3'b111;
    end else begin
      case (idx)
        2'd0: begin
          out   <= d0;
          invAn <= 3'b110;
        end
        2'd1: begin
          out   <= d1;
          invAn <= 3'b101;
        end
        2'd2: begin
          out   <= d2;
          invAn <= 3'b011;
        end
        default: begin
          out   <= SEG_BLANK;
          invAn <= 3'b111;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_top.sv
// Bench for calc_top: directed and random operand/opcode vectors checked
// slot by slot against an arithmetic model of the decimal display.
module tb_calc_top;

  localparam int DIV = 4;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;
  localparam logic [6:0] EE = 7'b0000110;
  localparam logic [6:0] RR = 7'b0101111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic [2:0] op = 3'd0;
  logic [6:0] out;
  logic [2:0] invAn;

  int total = 0;
  int bad = 0;

  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  calc_top #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .out(out), .invAn(invAn)
  );

  always #5 clk = ~clk;

  function automatic void model(input int av, input int bv, input int opv,
                                output logic [6:0] e2, output logic [6:0] e1, output logic [6:0] e0);
    int v = 0;
    int m;
    bit err = 0;
    case (opv)
      0: v = av + bv;
      1: v = av - bv;
      2: v = av * bv;
      3: if (bv == 0) err = 1; else v = av / bv;
      4: if (bv == 0) err = 1; else v = av % bv;
      5: v = av & bv;
      6: v = av | bv;
      default: v = av ^ bv;
    endcase
    if (err) begin
      e2 = EE; e1 = RR; e0 = RR;
    end else if (v < 0) begin
      m  = -v;
      e2 = MI;
      e1 = (m < 10) ? BL : segtab[m / 10];
      e0 = segtab[m % 10];
    end else begin
      e2 = (v / 100 == 0) ? BL : segtab[v / 100];
      e1 = (v < 10) ? BL : segtab[(v / 10) % 10];
      e0 = segtab[v % 10];
    end
  endfunction

  task automatic check_out(input logic [6:0] exp, input string tag);
    total++;
    assert (out === exp) else begin
      bad++;
      $error("FAIL %s an=%b out=%b expected=%b", tag, invAn, out, exp);
    end
  endtask

  task automatic check_an(input logic [2:0] exp, input string tag);
    total++;
    assert (invAn === exp) else begin
      bad++;
      $error("FAIL %s invAn=%b expected=%b", tag, invAn, exp);
    end
  endtask

  // One full scan; the expected segment is chosen by whichever anode is active.
  task automatic check_scan(input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0, input string tag);
    logic [6:0] exp;
    bit ok;
    for (int i = 0; i < 3 * DIV; i++) begin
      @(negedge clk);
      ok = (invAn === 3'b110) || (invAn === 3'b101) || (invAn === 3'b011);
      total++;
      assert (ok) else begin
        bad++;
        $error("FAIL %s_anode invAn=%b expected one-low", tag, invAn);
      end
      case (invAn)
        3'b110:  exp = e0;
        3'b101:  exp = e1;
        3'b011:  exp = e2;
        default: exp = BL;
      endcase
      check_out(exp, tag);
    end
  endtask

  // After reset release: fixed anode order from digit 0, out checked from cycle first_ok.
  task automatic check_after_reset(input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0,
                                   input int first_ok, input string tag);
    logic [2:0] ea;
    logic [6:0] eo;
    for (int k = 1; k <= 3 * DIV; k++) begin
      @(negedge clk);
      if (k <= DIV) begin
        ea = 3'b110; eo = e0;
      end else if (k <= 2 * DIV) begin
        ea = 3'b101; eo = e1;
      end else begin
        ea = 3'b011; eo = e2;
      end
      check_an(ea, tag);
      if (k >= first_ok) check_out(eo, tag);
    end
  endtask

  task automatic apply(input int av, input int bv, input int opv, input string tag);
    logic [6:0] e2, e1, e0;
    @(negedge clk);
    a = 4'(av); b = 4'(bv); op = 3'(opv);
    model(av, bv, opv, e2, e1, e0);
    repeat (3) @(negedge clk);
    check_scan(e2, e1, e0, tag);
  endtask

  initial begin
    logic [6:0] e2, e1, e0;
    int ra, rb, rop;

    #1 rst = 1'b1;
    #1;
    check_out(BL, "rst_async_out");
    check_an(3'b111, "rst_async_an");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_out(BL, "rst_hold_out");
      check_an(3'b111, "rst_hold_an");
    end
    rst = 1'b0;
    model(0, 0, 0, e2, e1, e0);
    check_after_reset(e2, e1, e0, 1, "scan_after_rst");

    apply(5, 5, 6, "or_5");
    apply(5, 5, 0, "add_10");
    apply(3, 5, 1, "sub_neg2");
    apply(15, 8, 2, "mul_120");
    apply(15, 15, 2, "mul_225");
    apply(5, 2, 3, "div_2");
    apply(9, 6, 4, "mod_3");
    apply(12, 3, 5, "and_0");
    apply(7, 0, 3, "div_zero");
    apply(7, 0, 4, "mod_zero");
    apply(0, 15, 1, "sub_neg15");
    apply(15, 15, 0, "add_30");
    apply(10, 3, 7, "xor_9");

    for (int n = 0; n < 30; n++) begin
      ra  = int'($urandom_range(0, 15));
      rb  = int'($urandom_range(0, 15));
      rop = int'($urandom_range(0, 7));
      apply(ra, rb, rop, "random");
    end

    // Reset pulse mid-scan with fresh inputs already applied.
    @(negedge clk);
    a = 4'd9; b = 4'd9; op = 3'd2;
    model(9, 9, 2, e2, e1, e0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_out(BL, "midrst_async_out");
    check_an(3'b111, "midrst_async_an");
    @(negedge clk);
    check_out(BL, "midrst_hold_out");
    check_an(3'b111, "midrst_hold_an");
    rst = 1'b0;
    check_after_reset(e2, e1, e0, 3, "scan_after_midrst");
    check_scan(e2, e1, e0, "after_midrst_steady");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
